// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_DONE
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] F3_SB = 2'b00;
    localparam logic [1:0] F3_SH = 2'b01;
    localparam logic [1:0] F3_SW = 2'b10;

    localparam logic [3:0] MEM_RD_WORD = 4'b1010;
    localparam logic [2:0] MEM_WR_WORD = 3'b110;

    // Size code is funct3[1:0]: 00 byte, 01 half, 10 word, 11 has no legal size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            2'b10:   return (addr_lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Byte/halfword lane extraction with sign/zero extension for loads,
// and lane merge of store data into a memory word for sub-word stores.
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] word_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic [XLEN-1:0] load_data_o,
    output logic [XLEN-1:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        load_data_o = word_i;
        case (funct3_i)
            F3_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  load_data_o = {24'd0, byte_sel};
            F3_LHU:  load_data_o = {16'd0, half_sel};
            default: load_data_o = word_i;
        endcase
    end

    // Only the addressed lane takes store data; the rest keep the read word.
    always_comb begin
        merged_o = word_i;
        case (funct3_i[1:0])
            F3_SB: begin
                case (addr_lo_i)
                    2'd0:    merged_o[7:0]   = store_data_i[7:0];
                    2'd1:    merged_o[15:8]  = store_data_i[7:0];
                    2'd2:    merged_o[23:16] = store_data_i[7:0];
                    default: merged_o[31:24] = store_data_i[7:0];
                endcase
            end
            F3_SH: begin
                if (addr_lo_i[1]) merged_o[31:16] = store_data_i[15:0];
                else              merged_o[15:0]  = store_data_i[15:0];
            end
            default: merged_o = store_data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MA-stage load/store initiator: turns RV32I loads/stores into aligned word
// transactions, with read-modify-write for SB/SH and fault detection.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [3:0]      cpu_read,
    input  logic [2:0]      cpu_write,
    input  logic [XLEN-1:0] cpu_address,
    input  logic [XLEN-1:0] cpu_writedata,
    output logic [XLEN-1:0] cpu_readdata,
    output logic            cpu_busywait,
    output logic            cpu_fault,
    output logic [3:0]      mem_read,
    output logic [2:0]      mem_write,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_writedata,
    input  logic [XLEN-1:0] mem_readdata,
    input  logic            mem_busywait
);

    lsu_state_e      state_q, state_d;
    logic [XLEN-1:0] cpu_readdata_q, cpu_readdata_d;
    logic            cpu_fault_q, cpu_fault_d;
    logic [3:0]      mem_read_q, mem_read_d;
    logic [2:0]      mem_write_q, mem_write_d;
    logic [XLEN-1:0] mem_address_q, mem_address_d;
    logic [XLEN-1:0] mem_writedata_q, mem_writedata_d;

    logic            load_en_c, store_en_c, load_legal_c, req_fault_c;
    logic [2:0]      lane_funct3_c;
    logic [XLEN-1:0] load_data_c, merged_c;

    assign load_en_c  = cpu_read[3];
    assign store_en_c = cpu_write[2];

    always_comb begin
        load_legal_c = (cpu_read[2:0] == F3_LB)  || (cpu_read[2:0] == F3_LH) ||
                       (cpu_read[2:0] == F3_LW)  || (cpu_read[2:0] == F3_LBU) ||
                       (cpu_read[2:0] == F3_LHU);
        req_fault_c  = (load_en_c & store_en_c) |
                       (load_en_c & (~load_legal_c | is_misaligned(cpu_read[1:0], cpu_address[1:0]))) |
                       (store_en_c & is_misaligned(cpu_write[1:0], cpu_address[1:0]));
        lane_funct3_c = load_en_c ? cpu_read[2:0] : {1'b0, cpu_write[1:0]};
    end

    lsu_lane_mux u_lane_mux (
        .funct3_i     (lane_funct3_c),
        .addr_lo_i    (cpu_address[1:0]),
        .word_i       (mem_readdata),
        .store_data_i (cpu_writedata),
        .load_data_o  (load_data_c),
        .merged_o     (merged_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cpu_readdata_q  <= '0;
            cpu_fault_q     <= 1'b0;
            mem_read_q      <= '0;
            mem_write_q     <= '0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
        end else begin
            state_q         <= state_d;
            cpu_readdata_q  <= cpu_readdata_d;
            cpu_fault_q     <= cpu_fault_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
        end
    end

    // mem_writedata_q doubles as the RMW merge register.
    always_comb begin
        state_d         = state_q;
        cpu_readdata_d  = cpu_readdata_q;
        cpu_fault_d     = cpu_fault_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;

        case (state_q)
            ST_IDLE: begin
                if (load_en_c | store_en_c) begin
                    if (req_fault_c) begin
                        state_d     = ST_DONE;
                        cpu_fault_d = 1'b1;
                    end else if (load_en_c) begin
                        state_d = ST_RD;
                    end else if (cpu_write[1:0] == F3_SW) begin
                        state_d         = ST_WR;
                        mem_writedata_d = cpu_writedata;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RD: begin
                if (!mem_busywait) begin
                    state_d        = ST_DONE;
                    cpu_readdata_d = load_data_c;
                end
            end
            ST_WR: begin
                if (!mem_busywait) state_d = ST_DONE;
            end
            ST_RMW_RD: begin
                if (!mem_busywait) begin
                    state_d         = ST_RMW_WR;
                    mem_writedata_d = merged_c;
                end
            end
            ST_RMW_WR: begin
                if (!mem_busywait) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                cpu_fault_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Requests are registered from the next state so they are live in that state.
        mem_read_d  = ((state_d == ST_RD) || (state_d == ST_RMW_RD)) ? MEM_RD_WORD : 4'b0000;
        mem_write_d = ((state_d == ST_WR) || (state_d == ST_RMW_WR)) ? MEM_WR_WORD : 3'b000;
        if ((state_d != ST_IDLE) && (state_d != ST_DONE))
            mem_address_d = {cpu_address[XLEN-1:2], 2'b00};
    end

    assign cpu_busywait  = (load_en_c | store_en_c) & (state_q != ST_DONE);
    assign cpu_readdata  = cpu_readdata_q;
    assign cpu_fault     = cpu_fault_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;

endmodule
